reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 167 ++++++++++++++++
 tb/tb_reg_file_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// reg_file_param
// Two-read / one-write register file with a self-clearing init sequence.
// After every reset the array is walked once, zeroing one entry per cycle,
// before normal writes are accepted.
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> an accepted write is forwarded to a read port addressing the
//                same entry in the same cycle
//   undefined -> same-cycle reads return the stored (old) value
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG 1 makes entry 0 read-only constant zero
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   rd_addr1/2 read addresses, rd_data1/2 combinational read data
//   wr_en, wr_addr, wr_data  write request, sampled on rising clk
//   init_busy  high while the post-reset clear sequence runs
//   wr_drop    one-cycle pulse: the previous cycle's write was discarded
// -----------------------------------------------------------------------------
module reg_file_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              init_busy,
   output logic              wr_drop
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              init_busy_q, init_busy_d;
   logic              wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              wr_zero_hit;
   logic              wr_accept;

   // -------------------------------------------------------------------------
   // Next-state and array write-port selection
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
      wr_accept   = (state_q == READY) && wr_en && !wr_zero_hit;

      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      init_busy_d = init_busy_q;
      wr_drop_d   = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = wr_addr;
      mem_wdata   = wr_data;

      case (state_q)
         CLEAR: begin
            // The clear sequence owns the write port; user writes are dropped.
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            wr_drop_d = wr_en;
            // All-ones counter means this cycle clears the last entry.
            if (&clr_cnt_q) begin
               state_d     = READY;
               init_busy_d = 1'b0;
            end
         end
         READY: begin
            mem_we    = wr_accept;
            wr_drop_d = wr_en && wr_zero_hit;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Control registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples values from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
         init_busy_q <= 1'b1;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_busy_q <= init_busy_d;
         wr_drop_q   <= wr_drop_d;
      end
   end

   // -------------------------------------------------------------------------
   // Storage array
   // -------------------------------------------------------------------------
   // NOTE: the array has no reset branch; the clear sequence zeroes it one
   // entry per cycle, which keeps it mappable onto plain RAM/flops without a
   // wide reset fan-out. Writes are simply blocked while rst_n is low.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // -------------------------------------------------------------------------
   // Read ports
   // -------------------------------------------------------------------------
   always_comb begin
      if (state_q == CLEAR) begin
         rd_data1 = '0;
      end else if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
         rd_data1 = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (rst_n && wr_accept && (rd_addr1 == wr_addr)) begin
         rd_data1 = wr_data;
`endif
      end else begin
         rd_data1 = mem_q[rd_addr1];
      end
   end

   always_comb begin
      if (state_q == CLEAR) begin
         rd_data2 = '0;
      end else if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
         rd_data2 = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (rst_n && wr_accept && (rd_addr2 == wr_addr)) begin
         rd_data2 = wr_data;
`endif
      end else begin
         rd_data2 = mem_q[rd_addr2];
      end
   end

   assign init_busy = init_busy_q;
   assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_reg_file_param
// Drives one stimulus stream into two instances (ZERO_REG=0 and ZERO_REG=1,
// DATA_W=16, ADDR_W=4) and compares both against a behavioural model built
// from arrays and an integer clear countdown.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

   localparam int DEPTH = 16;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rd_addr1, rd_addr2, wr_addr;
   logic [15:0] wr_data;
   logic        wr_en;

   logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        busy_a, busy_b, drop_a, drop_b;

   always #5 clk = ~clk;

   reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd1_a), .rd_data2(rd2_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .init_busy(busy_a), .wr_drop(drop_a)
   );

   reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd1_b), .rd_data2(rd2_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .init_busy(busy_b), .wr_drop(drop_b)
   );

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   int          tests = 0;
   int          fails = 0;
   logic [15:0] mem0 [DEPTH];   // ZERO_REG=0 contents
   logic [15:0] mem1 [DEPTH];   // ZERO_REG=1 contents
   int          clears_left;    // entries still to be zeroed; >0 means busy
   bit          m_drop0, m_drop1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_rd(input bit z, input logic [3:0] a,
                                          input bit rst, input bit we,
                                          input logic [3:0] wa,
                                          input logic [15:0] wd);
      bit accepted;
      accepted = rst && (clears_left == 0) && we && !(z && wa == 4'd0);
      if (clears_left > 0)            return 16'h0000;
      if (z && a == 4'd0)             return 16'h0000;
      if (BYPASS && accepted && a == wa) return wd;
      return z ? mem1[a] : mem0[a];
   endfunction

   // One clock cycle: apply inputs, check combinational and registered
   // outputs before the edge, then advance the model across the edge.
   task automatic cycle(input string tag, input bit rst, input bit we,
                        input logic [3:0] wa, input logic [15:0] wd,
                        input logic [3:0] a1, input logic [3:0] a2);
      rst_n = rst; wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr1 = a1; rd_addr2 = a2;
      #1;
      check({tag, ".rd1_z0"}, 32'(rd1_a), 32'(exp_rd(1'b0, a1, rst, we, wa, wd)));
      check({tag, ".rd2_z0"}, 32'(rd2_a), 32'(exp_rd(1'b0, a2, rst, we, wa, wd)));
      check({tag, ".rd1_z1"}, 32'(rd1_b), 32'(exp_rd(1'b1, a1, rst, we, wa, wd)));
      check({tag, ".rd2_z1"}, 32'(rd2_b), 32'(exp_rd(1'b1, a2, rst, we, wa, wd)));
      check({tag, ".busy_z0"}, 32'(busy_a), 32'(clears_left > 0));
      check({tag, ".busy_z1"}, 32'(busy_b), 32'(clears_left > 0));
      check({tag, ".drop_z0"}, 32'(drop_a), 32'(m_drop0));
      check({tag, ".drop_z1"}, 32'(drop_b), 32'(m_drop1));
      @(posedge clk);
      if (!rst) begin
         clears_left = DEPTH;
         m_drop0 = 1'b0;
         m_drop1 = 1'b0;
      end else if (clears_left > 0) begin
         mem0[DEPTH - clears_left] = 16'h0000;
         mem1[DEPTH - clears_left] = 16'h0000;
         clears_left--;
         m_drop0 = we;
         m_drop1 = we;
      end else begin
         m_drop0 = 1'b0;
         m_drop1 = we && (wa == 4'd0);
         if (we) mem0[wa] = wd;
         if (we && wa != 4'd0) mem1[wa] = wd;
      end
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int busy_cnt;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr1 = '0; rd_addr2 = '0;
      clears_left = DEPTH; m_drop0 = 1'b0; m_drop1 = 1'b0;

      // First reset: outputs undefined until this edge, so no checks yet.
      @(posedge clk);
      @(negedge clk);

      // Release; a write to addr 3 at clear cycle 4 must be dropped.
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy_a) busy_cnt++;
         cycle("clear1", 1'b1, (i == 4), 4'd3, 16'h1234, 4'(i), 4'(15 - i));
      end
      check("busy_len_first", 32'(busy_cnt), 32'd16);

      // Every entry reads zero after the clear.
      for (int i = 0; i < DEPTH; i++)
         cycle("all_zero", 1'b1, 1'b0, 4'd0, 16'h0, 4'(i), 4'(i));
      check("addr3_dropped", 32'(rd1_a), 32'(16'h0000)); // rd_addr1 left at 15
      cycle("rd3", 1'b1, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3);

      // Write 0xBEEF to addr 5, then read it on both ports.
      cycle("wr_beef", 1'b1, 1'b1, 4'd5, 16'hBEEF, 4'd1, 4'd2);
      cycle("rd_beef", 1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5);
      check("beef_port1", 32'(rd1_a), 32'(16'hBEEF));

      // Write 0xFFFF to addr 0: stored only without ZERO_REG.
      cycle("wr_zero", 1'b1, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd5);
      cycle("rd_zero", 1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      check("zero_reg_rd", 32'(rd1_b), 32'(16'h0000));

      // Same-cycle read of a written address.
      cycle("wr_aa", 1'b1, 1'b1, 4'd7, 16'h00AA, 4'd0, 4'd1);
      rst_n = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0055;
      rd_addr1 = 4'd7; rd_addr2 = 4'd7;
      #1;
      check("same_cycle_rd", 32'(rd1_a), BYPASS ? 32'h0055 : 32'h00AA);
      cycle("wr_55", 1'b1, 1'b1, 4'd7, 16'h0055, 4'd7, 4'd7);
      cycle("rd_55", 1'b1, 1'b0, 4'd0, 16'h0, 4'd7, 4'd7);
      check("next_cycle_rd", 32'(rd2_b), 32'h0055);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(0, 39) != 0), 1'($urandom),
               4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      end
      // Drain any clear left running by a late random reset.
      for (int i = 0; i < 17; i++)
         cycle("drain", 1'b1, 1'b0, 4'd0, 16'h0, 4'($urandom), 4'($urandom));

      // Fill addr 9, then reset and interrupt the clear at cycle 10.
      cycle("wr_5a", 1'b1, 1'b1, 4'd9, 16'h5A5A, 4'd9, 4'd0);
      cycle("rd_5a", 1'b1, 1'b0, 4'd0, 16'h0, 4'd9, 4'd9);
      check("fill9", 32'(rd1_a), 32'h5A5A);
      cycle("rst2", 1'b0, 1'b1, 4'd9, 16'h1111, 4'd9, 4'd9);
      for (int i = 0; i < 10; i++)
         cycle("clear2", 1'b1, 1'b0, 4'd0, 16'h0, 4'd9, 4'($urandom));
      cycle("rst3", 1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd9);
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy_a) busy_cnt++;
         cycle("clear3", 1'b1, 1'b0, 4'd0, 16'h0, 4'd9, 4'($urandom));
      end
      check("busy_len_restart", 32'(busy_cnt), 32'd16);
      check("addr9_cleared", 32'(rd1_a), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
